// File: rtl/byte_lane_loader.sv
// byte_lane_loader: packs a valid/ready byte stream into LANES byte lanes.
// It presents the completed lane set with a frame-valid flag and holds it until
// the downstream stage acknowledges it. Short and over-long frames are normalised
// and flagged.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   in_valid_i   : input byte valid
//   in_data_i    : input byte
//   in_last_i    : final byte of frame (qualified by in_valid_i)
//   in_ready_o   : loader can accept a byte (registered, state only)
//   lanes_o      : lane k at bits [k*DW +: DW]
//   lanes_vld_o  : lanes_o holds a complete frame
//   lanes_rdy_i  : downstream consumes the frame
//   frame_len_o  : real bytes in the held frame (1..LANES)
//   err_short_o  : held frame ended before LANES bytes
//   err_long_o   : held frame exceeded LANES bytes; excess discarded
module byte_lane_loader #(
  parameter  int unsigned LANES = 26,
  parameter  int unsigned DW    = 8,
  localparam int unsigned CW    = $clog2(LANES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  input  logic [DW-1:0]         in_data_i,
  input  logic                  in_last_i,
  output logic                  in_ready_o,
  output logic [LANES*DW-1:0]   lanes_o,
  output logic                  lanes_vld_o,
  input  logic                  lanes_rdy_i,
  output logic [CW-1:0]         frame_len_o,
  output logic                  err_short_o,
  output logic                  err_long_o
);

  localparam int unsigned LW = LANES * DW;
  localparam logic [CW-1:0] LAST_IDX = CW'(LANES - 1);
  localparam logic [CW-1:0] FULL_LEN = CW'(LANES);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LW-1:0]   r_lanes;
  logic [LW-1:0]   w_lanes_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   r_len;
  logic [CW-1:0]   w_len_nxt;
  logic            r_short;
  logic            w_short_nxt;
  logic            r_long;
  logic            w_long_nxt;
  logic            r_pend_long;
  logic            w_pend_long_nxt;
  logic            r_in_ready;
  logic            r_vld;
  logic            w_accept;

  // in_ready_o is registered, so an accept depends only on the current state.
  assign w_accept = in_valid_i & r_in_ready;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_lanes     <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_short     <= 1'b0;
      r_long      <= 1'b0;
      r_pend_long <= 1'b0;
      r_in_ready  <= 1'b1;
      r_vld       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lanes     <= w_lanes_nxt;
      r_cnt       <= w_cnt_nxt;
      r_len       <= w_len_nxt;
      r_short     <= w_short_nxt;
      r_long      <= w_long_nxt;
      r_pend_long <= w_pend_long_nxt;
      // Handshake outputs are decoded from the next state.
      // They are registered, so they have no combinational path from the inputs.
      r_in_ready  <= (w_state_nxt != HOLD);
      r_vld       <= (w_state_nxt == HOLD);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt     = r_state;
    w_lanes_nxt     = r_lanes;
    w_cnt_nxt       = r_cnt;
    w_len_nxt       = r_len;
    w_short_nxt     = r_short;
    w_long_nxt      = r_long;
    w_pend_long_nxt = r_pend_long;

    case (r_state)
      FILL: begin
        if (w_accept) begin
          for (int unsigned k = 0; k < LANES; k++) begin
            if (r_cnt == CW'(k)) begin
              w_lanes_nxt[k*DW +: DW] = in_data_i;
            end
          end
          w_cnt_nxt = CW'(r_cnt + 1'b1);
          if (in_last_i) begin
            w_state_nxt = HOLD;
            w_len_nxt   = CW'(r_cnt + 1'b1);
            // cnt+1 < LANES  <=>  cnt < LANES-1
            w_short_nxt = (r_cnt < LAST_IDX);
          end else if (r_cnt == LAST_IDX) begin
            w_state_nxt = DRAIN;
            w_len_nxt   = FULL_LEN;
          end
        end
      end

      DRAIN: begin
        // Excess bytes are swallowed; lanes are left untouched.
        if (w_accept) begin
          w_pend_long_nxt = 1'b1;
          if (in_last_i) begin
            w_state_nxt = HOLD;
            w_long_nxt  = w_pend_long_nxt;
          end
        end
      end

      HOLD: begin
        // Release clears lanes so that a short next frame reads zeros in its unused lanes.
        if (lanes_rdy_i) begin
          w_state_nxt     = FILL;
          w_lanes_nxt     = '0;
          w_cnt_nxt       = '0;
          w_len_nxt       = '0;
          w_short_nxt     = 1'b0;
          w_long_nxt      = 1'b0;
          w_pend_long_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  assign in_ready_o  = r_in_ready;
  assign lanes_o     = r_lanes;
  assign lanes_vld_o = r_vld;
  assign frame_len_o = r_len;
  assign err_short_o = r_short;
  assign err_long_o  = r_long;

endmodule

// File: tb/tb_byte_lane_loader.sv
module tb_byte_lane_loader;

  localparam int unsigned LANES = 26;
  localparam int unsigned DW    = 8;
  localparam int unsigned CW    = 5;
  localparam int unsigned LW    = LANES * DW;

  logic            clk_i;
  logic            rst_n;
  logic            in_valid_i;
  logic [DW-1:0]   in_data_i;
  logic            in_last_i;
  logic            in_ready_o;
  logic [LW-1:0]   lanes_o;
  logic            lanes_vld_o;
  logic            lanes_rdy_i;
  logic [CW-1:0]   frame_len_o;
  logic            err_short_o;
  logic            err_long_o;

  int tests;
  int failed;

  byte_lane_loader #(.LANES(LANES), .DW(DW)) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .in_ready_o  (in_ready_o),
    .lanes_o     (lanes_o),
    .lanes_vld_o (lanes_vld_o),
    .lanes_rdy_i (lanes_rdy_i),
    .frame_len_o (frame_len_o),
    .err_short_o (err_short_o),
    .err_long_o  (err_long_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int         n;
    logic [7:0] base;
    bit         gap;
    int         exp_len;
    bit         exp_short;
    bit         exp_long;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] exp_lanes(input int n, input logic [7:0] base);
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < n) v[k*DW +: DW] = 8'(base + 8'(k));
    end
    return v;
  endfunction

  // One byte, optionally preceded by an idle cycle carrying junk on data/last.
  task automatic send(input logic [7:0] d, input logic last, input bit gap, input bit chk_rdy);
    if (gap) begin
      @(negedge clk_i);
      in_valid_i = 1'b0;
      in_data_i  = 8'($urandom);
      in_last_i  = 1'($urandom);
      @(posedge clk_i);
    end
    @(negedge clk_i);
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    if (chk_rdy) chk("ready_before_byte", LW'(in_ready_o), LW'(1'b1));
    @(posedge clk_i);
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input bit gap);
    for (int i = 0; i < n; i++) begin
      send(8'(base + 8'(i)), (i == n - 1), gap && (i > 0), 1'b1);
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  // Called at the negedge right after the terminating accept.
  task automatic check_held(input int n, input logic [7:0] base, input int len,
                            input bit sh, input bit lg);
    chk("vld_after_last", LW'(lanes_vld_o), LW'(1'b1));
    chk("ready_in_hold", LW'(in_ready_o), LW'(1'b0));
    chk("lanes", lanes_o, exp_lanes(n, base));
    chk("frame_len", LW'(frame_len_o), LW'(len));
    chk("err_short", LW'(err_short_o), LW'(sh));
    chk("err_long", LW'(err_long_o), LW'(lg));
  endtask

  task automatic release_frame();
    lanes_rdy_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    lanes_rdy_i = 1'b0;
    chk("vld_after_release", LW'(lanes_vld_o), LW'(1'b0));
    chk("ready_after_release", LW'(in_ready_o), LW'(1'b1));
    chk("lanes_cleared", lanes_o, '0);
    chk("len_cleared", LW'(frame_len_o), '0);
    chk("errs_cleared", LW'({err_short_o, err_long_o}), '0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_lanes"}, lanes_o, '0);
    chk({tag, "_vld"}, LW'(lanes_vld_o), LW'(1'b0));
    chk({tag, "_ready"}, LW'(in_ready_o), LW'(1'b1));
    chk({tag, "_len"}, LW'(frame_len_o), '0);
    chk({tag, "_errs"}, LW'({err_short_o, err_long_o}), '0);
  endtask

  initial begin
    logic [LW-1:0] snap;
    tests  = 0;
    failed = 0;

    vecs[0] = '{26, 8'h01, 1'b0, 26, 1'b0, 1'b0};  // full frame
    vecs[1] = '{3,  8'hA0, 1'b0, 3,  1'b1, 1'b0};  // short frame
    vecs[2] = '{26, 8'h01, 1'b0, 26, 1'b0, 1'b0};  // full frame right after short: no residue
    vecs[3] = '{30, 8'h00, 1'b0, 26, 1'b0, 1'b1};  // long frame
    vecs[4] = '{26, 8'h01, 1'b1, 26, 1'b0, 1'b0};  // gapped input
    vecs[5] = '{1,  8'h55, 1'b0, 1,  1'b1, 1'b0};  // single byte
    vecs[6] = '{27, 8'h10, 1'b0, 26, 1'b0, 1'b1};  // one byte over
    vecs[7] = '{25, 8'hC0, 1'b1, 25, 1'b1, 1'b0};  // one byte short, gapped

    rst_n       = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_last_i   = 1'b0;
    lanes_rdy_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_vals("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].n, vecs[v].base, vecs[v].gap);
      check_held(vecs[v].n, vecs[v].base, vecs[v].exp_len, vecs[v].exp_short, vecs[v].exp_long);
      release_frame();
    end

    // Backpressure: hold the frame for 10 cycles while upstream keeps offering bytes.
    send_frame(26, 8'h01, 1'b0);
    check_held(26, 8'h01, 26, 1'b0, 1'b0);
    snap = lanes_o;
    for (int c = 0; c < 10; c++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'($urandom);
      in_last_i  = 1'($urandom);
      @(posedge clk_i);
      @(negedge clk_i);
      chk("bp_ready", LW'(in_ready_o), LW'(1'b0));
      chk("bp_vld", LW'(lanes_vld_o), LW'(1'b1));
      chk("bp_lanes", lanes_o, exp_lanes(26, 8'h01));
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    chk("bp_snapshot", snap, exp_lanes(26, 8'h01));
    release_frame();

    // Reset in the middle of a frame; the downstream ready in FILL must have no effect.
    lanes_rdy_i = 1'b1;
    for (int i = 0; i < 10; i++) send(8'(8'h30 + 8'(i)), 1'b0, 1'b0, 1'b1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    lanes_rdy_i = 1'b0;
    chk("partial_lanes", lanes_o, exp_lanes(10, 8'h30));
    chk("partial_vld", LW'(lanes_vld_o), LW'(1'b0));
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(negedge clk_i);
    rst_n = 1'b1;
    send_frame(2, 8'h77, 1'b0);
    check_held(2, 8'h77, 2, 1'b1, 1'b0);
    release_frame();

    // Reset while a frame is held.
    send_frame(4, 8'h90, 1'b0);
    check_held(4, 8'h90, 4, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("hold_reset");
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    check_reset_vals("after_hold_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/byte_lane_loader.md
# byte_lane_loader

Upstream feeder for the 26-lane byte-parallel compute stage. Accepts a byte stream over a valid/ready handshake, deposits consecutive bytes into lanes a..z (lane 0 = a), and presents the completed lane set with a frame-valid flag. Lanes stay stable until the downstream stage acknowledges them. Short and over-long frames are normalised and flagged.

## Interface
- LANES, 26, number of byte lanes presented downstream (1..31)
- DW, 8, lane width in bits
- CW, derived $clog2(LANES+1), width of count/length fields (5 at defaults)

- clk_i  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid_i  in  1  input byte valid
- in_data_i  in  DW  input byte
- in_last_i  in  1  marks final byte of a frame; qualified by in_valid_i
- in_ready_o  out  1  loader can accept a byte
- lanes_o  out  LANES*DW  lane k at bits [k*DW+DW-1 : k*DW]; lane 0 feeds data_a, lane 25 feeds data_z
- lanes_vld_o  out  1  lanes_o holds a complete frame
- lanes_rdy_i  in  1  downstream consumes the frame
- frame_len_o  out  CW  count of real bytes in the held frame (1..LANES)
- err_short_o  out  1  held frame ended before LANES bytes (valid with lanes_vld_o)
- err_long_o  out  1  held frame had more than LANES bytes; excess discarded

## Operation
- Accept = in_valid_i & in_ready_o. Downstream handshake = lanes_vld_o & lanes_rdy_i.
- States: FILL, DRAIN, HOLD. Reset state: FILL.
- FILL: in_ready_o=1. Each accept writes in_data_i into lane[cnt], cnt++.
  - Accept with in_last_i: go to HOLD; frame_len_o=cnt+1; err_short_o=(cnt+1<LANES).
  - Accept without in_last_i when cnt==LANES-1: lane set complete; go to DRAIN; frame_len_o=LANES.
- DRAIN: in_ready_o=1; accepted bytes are discarded (lanes unchanged). Any accept sets a pending long flag. Accept with in_last_i: go to HOLD; err_long_o=pending flag.
  - A frame of exactly LANES bytes ends with in_last_i on the LANES-th byte in FILL, so it never enters DRAIN and has no error.
- HOLD: in_ready_o=0; lanes_vld_o=1; lanes_o, frame_len_o and error flags held stable. On downstream handshake: all lanes cleared to 0, cnt=0, flags cleared, state FILL.
- Unwritten lanes of a short frame read 0 because lanes are cleared on each frame release.
- in_data_i and in_last_i are ignored when no accept occurs.
- Downstream may assert lanes_rdy_i at any time. It has effect only in HOLD.

## Timing
- Reset (async assert, sync deassert at the source): lanes_o=0, lanes_vld_o=0, in_ready_o=1, frame_len_o=0, err_short_o=0, err_long_o=0, cnt=0.
- Reset mid-frame or mid-HOLD discards the frame immediately. No partial frame survives reset.
- Latency: lanes_vld_o rises on the clock edge that accepts the terminating byte (in_last_i in FILL or DRAIN). It is visible the cycle after that accept.
- Release: lanes_vld_o falls and in_ready_o rises on the edge after the downstream handshake. There is one bubble cycle per frame, with no accept in the handshake cycle.
- Maximum throughput: one byte per cycle while filling. A full frame of LANES bytes takes LANES+1 cycles minimum including release.
- in_ready_o is a registered function of state only. It has no combinational path from lanes_rdy_i or in_valid_i.
- lanes_vld_o must not deassert without a handshake. All outputs are registered.

## Test plan
- Full frame: 26 accepts of bytes 0x01..0x1A, last on the 26th, lanes_rdy_i=0 -> lanes_o lane k = k+1; frame_len_o=26; both errors 0; in_ready_o=0 until rdy is asserted.
- Short frame: bytes 0xA0,0xA1,0xA2 with last on the 3rd -> lanes 0..2 = A0..A2, lanes 3..25 = 0, frame_len_o=3, err_short_o=1. A following 26-byte frame shows no residue and err_short_o=0.
- Long frame: 30 bytes 0x00..0x1D with last on the 30th -> lanes hold 0x00..0x19, frame_len_o=26, err_long_o=1; in_ready_o stays 1 through bytes 27..30.
- Backpressure: hold lanes_rdy_i=0 for 10 cycles while in_valid_i=1 -> in_ready_o=0 and lanes_o unchanged. Then rdy=1 for 1 cycle -> lanes_vld_o=0 next cycle and lanes read 0.
- Gapped input: in_valid_i toggling 1/0 with random data during the 0 cycles for a 26-byte frame -> only valid bytes land in lanes; the result is identical to the full-frame case.
- Reset: assert rst_n=0 after 10 accepted bytes -> all outputs at reset values immediately. After release, a 2-byte frame yields frame_len_o=2, lanes 0..1 correct, and the rest 0.
